// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: byte FIFO between the 16x-oversampled UART receiver and host logic.
// Define RX_FIFO_LEVEL_EN to add the level / almost_full status outputs.
`timescale 1ns/1ps
module uart_rx_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int AF_THRESH  = 12
) (
  input  logic                clk_50m,
  input  logic                rst_n,
  input  logic                rx_rdy,
  input  logic [7:0]          rx_data,
  output logic                rx_rdy_clr,
  output logic [7:0]          rd_data,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic                overrun,
  input  logic                ovr_clr
`ifdef RX_FIFO_LEVEL_EN
  ,
  output logic [DEPTH_LOG2:0] level,
  output logic                almost_full
`endif
);

  localparam logic [DEPTH_LOG2:0]   CNT_ZERO = {(DEPTH_LOG2+1){1'b0}};
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2-1:0] PTR_ZERO = {DEPTH_LOG2{1'b0}};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  logic [7:0]            mem_r [0:(1<<DEPTH_LOG2)-1];
  logic [DEPTH_LOG2-1:0] wptr_r;
  logic [DEPTH_LOG2-1:0] rptr_r;
  logic [DEPTH_LOG2:0]   count_r;
  logic                  rx_rdy_clr_r;
  logic                  overrun_r;

  logic cap_s;
  logic full_s;
  logic empty_s;
  logic pop_s;
  logic push_s;
  logic drop_s;

  // Capture is masked during the clear pulse: the receiver still holds rdy high that cycle.
  always_comb begin
    cap_s   = rx_rdy & ~rx_rdy_clr_r;
    full_s  = (count_r == CNT_FULL);
    empty_s = (count_r == CNT_ZERO);
    pop_s   = ~empty_s & rd_ready;
    push_s  = cap_s & (~full_s | pop_s);
    drop_s  = cap_s & full_s & ~pop_s;
  end

  // Pointers, occupancy, receiver clear pulse and sticky overrun flag.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      wptr_r       <= PTR_ZERO;
      rptr_r       <= PTR_ZERO;
      count_r      <= CNT_ZERO;
      rx_rdy_clr_r <= 1'b0;
      overrun_r    <= 1'b0;
    end else begin
      rx_rdy_clr_r <= cap_s;
      if (push_s) begin
        wptr_r <= wptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rptr_r <= rptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
      if (drop_s) begin
        overrun_r <= 1'b1;
      end else if (ovr_clr) begin
        overrun_r <= 1'b0;
      end
    end
  end

  // Byte storage; deliberately not reset.
  always_ff @(posedge clk_50m) begin
    if (push_s) begin
      mem_r[wptr_r] <= rx_data;
    end
  end

  assign rx_rdy_clr = rx_rdy_clr_r;
  assign overrun    = overrun_r;
  assign rd_valid   = ~empty_s;
  assign rd_data    = mem_r[rptr_r];

`ifdef RX_FIFO_LEVEL_EN
  localparam logic [DEPTH_LOG2:0] AF_LVL = AF_THRESH[DEPTH_LOG2:0];

  assign level       = count_r;
  assign almost_full = (count_r >= AF_LVL);
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: randomized scoreboard bench for uart_rx_fifo against a queue-based reference model.
`timescale 1ns/1ps
module tb_uart_rx_fifo;

  logic       clk_50m = 1'b0;
  logic       rst_n;
  logic       rx_rdy;
  logic [7:0] rx_data;
  logic       rx_rdy_clr;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready;
  logic       overrun;
  logic       ovr_clr;
`ifdef RX_FIFO_LEVEL_EN
  logic [4:0] level;
  logic       almost_full;
`endif

  int errors   = 0;
  int checks   = 0;
  int n_popped = 0;
  bit done_send;

  byte unsigned fifo_m[$];
  byte unsigned sb_q[$];
  logic exp_clr;
  logic exp_ovr;

  always #10 clk_50m = ~clk_50m;

  uart_rx_fifo #(.DEPTH_LOG2(4), .AF_THRESH(12)) dut (
    .clk_50m    (clk_50m),
    .rst_n      (rst_n),
    .rx_rdy     (rx_rdy),
    .rx_data    (rx_data),
    .rx_rdy_clr (rx_rdy_clr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .overrun    (overrun),
    .ovr_clr    (ovr_clr)
`ifdef RX_FIFO_LEVEL_EN
    ,
    .level      (level),
    .almost_full(almost_full)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a 16-entry queue advanced once per clock from the rules of the block.
  always @(posedge clk_50m or negedge rst_n) begin
    bit cap;
    bit pop;
    bit full;
    if (!rst_n) begin
      fifo_m.delete();
      sb_q.delete();
      exp_clr = 1'b0;
      exp_ovr = 1'b0;
    end else begin
      cap  = rx_rdy && !exp_clr;
      full = (fifo_m.size() == 16);
      pop  = (fifo_m.size() != 0) && rd_ready;
      if (pop) void'(fifo_m.pop_front());
      if (cap && (!full || pop)) begin
        fifo_m.push_back(rx_data);
        sb_q.push_back(rx_data);
      end
      if (cap && full && !pop) exp_ovr = 1'b1;
      else if (ovr_clr) exp_ovr = 1'b0;
      exp_clr = cap;
    end
  end

  // Monitor: compares DUT state each cycle and pops the scoreboard on every read handshake.
  always @(negedge clk_50m) begin
    if (rst_n) begin
      check("rx_rdy_clr", rx_rdy_clr, exp_clr);
      check("rd_valid", rd_valid, fifo_m.size() != 0);
      check("overrun", overrun, exp_ovr);
      if (rd_valid && fifo_m.size() != 0) check("rd_head", rd_data, fifo_m[0]);
`ifdef RX_FIFO_LEVEL_EN
      check("level", level, fifo_m.size());
      check("almost_full", almost_full, fifo_m.size() >= 12);
`endif
      if (rd_valid && rd_ready) begin
        if (sb_q.size() == 0) check("pop_with_empty_scoreboard", rd_valid, 1'b0);
        else begin
          check("rd_data", rd_data, sb_q.pop_front());
          n_popped++;
        end
      end
    end
  end

  task automatic wait_clr_release();
    int n = 0;
    do begin
      @(posedge clk_50m); #4;
      n++;
    end while (!rx_rdy_clr && n < 20);
    check("clr_seen", rx_rdy_clr, 1'b1);
    @(posedge clk_50m); #4;
    rx_rdy = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_rdy  = 1'b1;
    wait_clr_release();
  endtask

  task automatic drain();
    int n = 0;
    rd_ready = 1'b1;
    while (fifo_m.size() != 0 && n < 100) begin
      @(posedge clk_50m); #4;
      n++;
    end
    @(posedge clk_50m); #4;
    rd_ready = 1'b0;
    check("drain_rd_valid", rd_valid, 1'b0);
  endtask

  initial begin
    int p0;
    int cyc;
    rst_n = 1'b0; rx_rdy = 1'b0; rx_data = 8'h00; rd_ready = 1'b0; ovr_clr = 1'b0;
    done_send = 1'b0;
    repeat (3) @(posedge clk_50m);
    #4 rst_n = 1'b1;
    check("rst_rd_valid", rd_valid, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_clr", rx_rdy_clr, 1'b0);

    // single byte, then pop
    send_byte(8'hA5);
    check("single_valid", rd_valid, 1'b1);
    check("single_data", rd_data, 8'hA5);
    rd_ready = 1'b1;
    @(posedge clk_50m); #4;
    rd_ready = 1'b0;
    check("single_empty", rd_valid, 1'b0);

    // double-capture guard
    send_byte(8'h3C);
    repeat (2) begin @(posedge clk_50m); #4; end
    p0 = n_popped;
    drain();
    check("one_entry", n_popped - p0, 1);

    // fill and overrun
    for (int i = 0; i < 16; i++) send_byte(i[7:0]);
    send_byte(8'h10);
    check("fill_overrun", overrun, 1'b1);
    check("fill_valid", rd_valid, 1'b1);
    check("fill_head", rd_data, 8'h00);
    ovr_clr = 1'b1;
    @(posedge clk_50m); #4;
    ovr_clr = 1'b0;
    check("ovr_cleared", overrun, 1'b0);

    // full with simultaneous push and pop
    rx_data = 8'h55; rx_rdy = 1'b1; rd_ready = 1'b1;
    @(posedge clk_50m); #4;
    rd_ready = 1'b0;
    check("fullpop_clr", rx_rdy_clr, 1'b1);
    check("fullpop_overrun", overrun, 1'b0);
    check("fullpop_head", rd_data, 8'h01);
    @(posedge clk_50m); #4;
    rx_rdy = 1'b0;
    p0 = n_popped;
    drain();
    check("fullpop_drained", n_popped - p0, 16);

    // randomized traffic across pointer wrap
    cyc = 0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 3)) begin @(posedge clk_50m); #4; end
          send_byte(8'($urandom_range(0, 255)));
        end
        done_send = 1'b1;
      end
      begin
        while (!(done_send && fifo_m.size() == 0) && cyc < 3000) begin
          rd_ready = 1'($urandom_range(0, 1));
          @(posedge clk_50m); #4;
          cyc++;
        end
        rd_ready = 1'b0;
      end
    join
    check("rand_drained", rd_valid, 1'b0);

    // reset mid-stream with 5 bytes queued and a clear pulse in flight
    for (int i = 0; i < 5; i++) send_byte(8'hC0 + i[7:0]);
    rx_data = 8'hEE; rx_rdy = 1'b1;
    @(posedge clk_50m); #4;
    check("pre_rst_clr", rx_rdy_clr, 1'b1);
    check("pre_rst_valid", rd_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_async_valid", rd_valid, 1'b0);
    check("rst_async_overrun", overrun, 1'b0);
    check("rst_async_clr", rx_rdy_clr, 1'b0);
    repeat (2) @(posedge clk_50m);
    #4 rst_n = 1'b1;
    wait_clr_release();
    check("post_rst_valid", rd_valid, 1'b1);
    check("post_rst_data", rd_data, 8'hEE);
    p0 = n_popped;
    drain();
    check("post_rst_count", n_popped - p0, 1);

`ifdef RX_FIFO_LEVEL_EN
    for (int i = 0; i < 12; i++) send_byte(8'h80 + i[7:0]);
    check("lvl12", level, 12);
    check("af12", almost_full, 1'b1);
    rd_ready = 1'b1;
    @(posedge clk_50m); #4;
    rd_ready = 1'b0;
    check("lvl11", level, 11);
    check("af11", almost_full, 1'b0);
    drain();
`endif

    repeat (3) begin @(posedge clk_50m); #4; end
    check("final_empty", rd_valid, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
